// File: rtl/rd_req_arbiter.sv
// Read-request arbiter: shares one PCIe read-request channel between config and user requesters, counts requests in flight and routes completions by tag.
// Optional build macro RD_ARB_CFG_PRIORITY_EN: strict priority to cfg instead of round-robin.
`timescale 1ns/1ps
module rd_req_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        i_pcie_clk,
  input  logic        i_rst,
  input  logic        cfg_rd_req_i,
  input  logic [31:0] cfg_rd_req_addr_i,
  input  logic [11:0] cfg_rd_req_len_i,
  output logic        cfg_rd_req_ack_o,
  input  logic        usr_rd_req_i,
  input  logic [31:0] usr_rd_req_addr_i,
  input  logic [11:0] usr_rd_req_len_i,
  output logic        usr_rd_req_ack_o,
  output logic        rd_req_o,
  output logic [31:0] rd_req_addr_o,
  output logic [11:0] rd_req_len_o,
  output logic [7:0]  rd_req_tag_o,
  input  logic        rd_req_ack_i,
  input  logic        cpl_valid_i,
  input  logic [7:0]  cpl_tag_i,
  input  logic [63:0] cpl_data_i,
  input  logic        cpl_last_i,
  output logic [63:0] cfg_data_o,
  output logic        cfg_data_valid_o,
  output logic [63:0] usr_data_o,
  output logic        usr_data_valid_o,
  output logic [3:0]  outstanding_o,
  output logic        err_o
);

  localparam logic [3:0] OUT_MAX = 4'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t     state;
  logic       owner_usr;
  logic       last_usr;
  logic [6:0] seq;
  logic       grant_usr;
  logic       can_grant;
  logic       accept;
  logic       cpl_done;
  logic       unused_tag_bits;

  // Only the owner bit of a completion tag steers routing.
  assign unused_tag_bits = ^cpl_tag_i[6:0];

  always_comb begin
`ifdef RD_ARB_CFG_PRIORITY_EN
    grant_usr = ~cfg_rd_req_i;
`else
    if (cfg_rd_req_i && usr_rd_req_i) grant_usr = ~last_usr;
    else                              grant_usr = usr_rd_req_i;
`endif
  end

  always_comb begin
    can_grant        = (cfg_rd_req_i || usr_rd_req_i) && (outstanding_o < OUT_MAX);
    accept           = rd_req_ack_i && (state == ISSUE);
    cpl_done         = cpl_valid_i && cpl_last_i;
    cfg_rd_req_ack_o = accept && !owner_usr;
    usr_rd_req_ack_o = accept && owner_usr;
  end

  always_ff @(posedge i_pcie_clk) begin
    if (i_rst) begin
      state            <= IDLE;
      rd_req_o         <= 1'b0;
      rd_req_addr_o    <= '0;
      rd_req_len_o     <= '0;
      rd_req_tag_o     <= '0;
      owner_usr        <= 1'b0;
      last_usr         <= 1'b1;
      seq              <= '0;
      outstanding_o    <= '0;
      err_o            <= 1'b0;
      cfg_data_valid_o <= 1'b0;
      usr_data_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (can_grant) begin
            state         <= ISSUE;
            rd_req_o      <= 1'b1;
            owner_usr     <= grant_usr;
            last_usr      <= grant_usr;
            rd_req_addr_o <= grant_usr ? usr_rd_req_addr_i : cfg_rd_req_addr_i;
            rd_req_len_o  <= grant_usr ? usr_rd_req_len_i : cfg_rd_req_len_i;
            rd_req_tag_o  <= {grant_usr, seq};
          end
        end
        ISSUE: begin
          if (rd_req_ack_i) begin
            state    <= GAP;
            rd_req_o <= 1'b0;
            seq      <= seq + 7'd1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase

      // A last beat with nothing in flight is routed but never underflows the count.
      if (accept && !cpl_done)
        outstanding_o <= outstanding_o + 4'd1;
      else if (!accept && cpl_done && (outstanding_o != 4'd0))
        outstanding_o <= outstanding_o - 4'd1;

      if ((rd_req_ack_i && (state != ISSUE)) || (cpl_done && (outstanding_o == 4'd0)))
        err_o <= 1'b1;

      cfg_data_valid_o <= cpl_valid_i && !cpl_tag_i[7];
      usr_data_valid_o <= cpl_valid_i && cpl_tag_i[7];
    end
  end

  always_ff @(posedge i_pcie_clk) begin
    cfg_data_o <= cpl_data_i;
    usr_data_o <= cpl_data_i;
  end

endmodule

// File: tb/tb_rd_req_arbiter.sv
// Self-checking bench for rd_req_arbiter: directed scenarios plus randomized traffic against a transaction-level model.
`timescale 1ns/1ps
module tb_rd_req_arbiter;

  localparam int unsigned MAXO = 4;

  logic        i_pcie_clk;
  logic        i_rst;
  logic        cfg_rd_req_i;
  logic [31:0] cfg_rd_req_addr_i;
  logic [11:0] cfg_rd_req_len_i;
  logic        cfg_rd_req_ack_o;
  logic        usr_rd_req_i;
  logic [31:0] usr_rd_req_addr_i;
  logic [11:0] usr_rd_req_len_i;
  logic        usr_rd_req_ack_o;
  logic        rd_req_o;
  logic [31:0] rd_req_addr_o;
  logic [11:0] rd_req_len_o;
  logic [7:0]  rd_req_tag_o;
  logic        rd_req_ack_i;
  logic        cpl_valid_i;
  logic [7:0]  cpl_tag_i;
  logic [63:0] cpl_data_i;
  logic        cpl_last_i;
  logic [63:0] cfg_data_o;
  logic        cfg_data_valid_o;
  logic [63:0] usr_data_o;
  logic        usr_data_valid_o;
  logic [3:0]  outstanding_o;
  logic        err_o;

  rd_req_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .i_pcie_clk(i_pcie_clk), .i_rst(i_rst),
    .cfg_rd_req_i(cfg_rd_req_i), .cfg_rd_req_addr_i(cfg_rd_req_addr_i),
    .cfg_rd_req_len_i(cfg_rd_req_len_i), .cfg_rd_req_ack_o(cfg_rd_req_ack_o),
    .usr_rd_req_i(usr_rd_req_i), .usr_rd_req_addr_i(usr_rd_req_addr_i),
    .usr_rd_req_len_i(usr_rd_req_len_i), .usr_rd_req_ack_o(usr_rd_req_ack_o),
    .rd_req_o(rd_req_o), .rd_req_addr_o(rd_req_addr_o), .rd_req_len_o(rd_req_len_o),
    .rd_req_tag_o(rd_req_tag_o), .rd_req_ack_i(rd_req_ack_i),
    .cpl_valid_i(cpl_valid_i), .cpl_tag_i(cpl_tag_i), .cpl_data_i(cpl_data_i),
    .cpl_last_i(cpl_last_i),
    .cfg_data_o(cfg_data_o), .cfg_data_valid_o(cfg_data_valid_o),
    .usr_data_o(usr_data_o), .usr_data_valid_o(usr_data_valid_o),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  initial begin
    i_pcie_clk = 1'b0;
    forever #5 i_pcie_clk = ~i_pcie_clk;
  end

  // Reference model state: transaction-level view of the arbiter.
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;
  int unsigned m_out;
  bit          m_err;
  bit          m_last_usr;
  logic [6:0]  m_seq;
  logic [7:0]  inflight[$];
  logic [7:0]  last_tag_seen;
  int unsigned last_issue_cyc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_pcie_clk);
    #1;
    cyc++;
  endtask

  function automatic bit model_pick();
`ifdef RD_ARB_CFG_PRIORITY_EN
    return !cfg_rd_req_i;
`else
    if (cfg_rd_req_i && usr_rd_req_i) return !m_last_usr;
    return usr_rd_req_i;
`endif
  endfunction

  task automatic do_reset();
    i_rst = 1'b1;
    cfg_rd_req_i = 1'b0; usr_rd_req_i = 1'b0;
    rd_req_ack_i = 1'b0; cpl_valid_i = 1'b0; cpl_last_i = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;
    m_out = 0; m_err = 1'b0; m_last_usr = 1'b1; m_seq = '0;
    inflight.delete();
    chk("rst_rd_req", rd_req_o, 1'b0);
    chk("rst_outstanding", outstanding_o, 0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_valids", {cfg_data_valid_o, usr_data_valid_o}, 0);
    chk("rst_acks", {cfg_rd_req_ack_o, usr_rd_req_ack_o}, 0);
  endtask

  task automatic set_cfg(input logic [31:0] a, input logic [11:0] l);
    cfg_rd_req_i = 1'b1; cfg_rd_req_addr_i = a; cfg_rd_req_len_i = l;
  endtask

  task automatic set_usr(input logic [31:0] a, input logic [11:0] l);
    usr_rd_req_i = 1'b1; usr_rd_req_addr_i = a; usr_rd_req_len_i = l;
  endtask

  // One full request: grant, hold for `delay` cycles, ack, GAP with requester lagging.
  task automatic do_issue(input int unsigned delay, input bit drop, input bit with_cpl);
    bit          pick;
    logic [7:0]  etag;
    logic [31:0] eaddr;
    logic [11:0] elen;
    logic [7:0]  ctag;
    logic [63:0] cdat;
    pick  = model_pick();
    etag  = {pick, m_seq};
    eaddr = pick ? usr_rd_req_addr_i : cfg_rd_req_addr_i;
    elen  = pick ? usr_rd_req_len_i : cfg_rd_req_len_i;
    ctag  = '0;
    cdat  = '0;
    tick();
    chk("issue_req", rd_req_o, 1'b1);
    chk("issue_addr", rd_req_addr_o, eaddr);
    chk("issue_len", rd_req_len_o, elen);
    chk("issue_tag", rd_req_tag_o, etag);
    last_tag_seen  = rd_req_tag_o;
    last_issue_cyc = cyc;
    repeat (delay) begin
      tick();
      chk("hold_req", rd_req_o, 1'b1);
      chk("hold_tag", rd_req_tag_o, etag);
      chk("no_early_ack", {cfg_rd_req_ack_o, usr_rd_req_ack_o}, 0);
    end
    rd_req_ack_i = 1'b1;
    if (with_cpl) begin
      ctag = inflight.pop_front();
      cdat = {$urandom, $urandom};
      cpl_valid_i = 1'b1; cpl_last_i = 1'b1; cpl_tag_i = ctag; cpl_data_i = cdat;
    end
    #1;
    chk("cfg_ack", cfg_rd_req_ack_o, !pick);
    chk("usr_ack", usr_rd_req_ack_o, pick);
    tick();
    rd_req_ack_i = 1'b0; cpl_valid_i = 1'b0; cpl_last_i = 1'b0;
    m_seq      = m_seq + 7'd1;
    m_last_usr = pick;
    if (!with_cpl) m_out++;
    inflight.push_back(etag);
    chk("ack_drop", rd_req_o, 1'b0);
    chk("ack_outstanding", outstanding_o, m_out);
    if (with_cpl) begin
      chk("cpl_route", {cfg_data_valid_o, usr_data_valid_o}, {!ctag[7], ctag[7]});
      chk("cpl_data", ctag[7] ? usr_data_o : cfg_data_o, cdat);
    end
    tick();
    chk("gap_ignores", rd_req_o, 1'b0);
    if (drop) begin
      if (pick) usr_rd_req_i = 1'b0; else cfg_rd_req_i = 1'b0;
    end else begin
      if (pick) set_usr($urandom, 12'($urandom));
      else      set_cfg($urandom, 12'($urandom));
    end
  endtask

  task automatic do_cpl(input logic [7:0] tag, input bit last, input logic [63:0] data);
    cpl_valid_i = 1'b1; cpl_tag_i = tag; cpl_last_i = last; cpl_data_i = data;
    tick();
    cpl_valid_i = 1'b0; cpl_last_i = 1'b0;
    if (last) begin
      if (m_out > 0) m_out--;
      else           m_err = 1'b1;
    end
    chk("cpl_cfg_valid", cfg_data_valid_o, !tag[7]);
    chk("cpl_usr_valid", usr_data_valid_o, tag[7]);
    chk("cpl_data", tag[7] ? usr_data_o : cfg_data_o, data);
    chk("cpl_outstanding", outstanding_o, m_out);
    chk("cpl_err", err_o, m_err);
    tick();
    chk("cpl_valid_pulse", {cfg_data_valid_o, usr_data_valid_o}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned prev;
    bit          wc;
    i_rst = 1'b1;
    cfg_rd_req_i = 1'b0; cfg_rd_req_addr_i = '0; cfg_rd_req_len_i = '0;
    usr_rd_req_i = 1'b0; usr_rd_req_addr_i = '0; usr_rd_req_len_i = '0;
    rd_req_ack_i = 1'b0; cpl_valid_i = 1'b0; cpl_tag_i = '0; cpl_data_i = '0; cpl_last_i = 1'b0;

    // Single cfg request, ack two cycles after issue.
    do_reset();
    set_cfg(32'h0000_1000, 12'd0);
    do_issue(2, 1'b1, 1'b0);
    chk("first_tag", last_tag_seen, 8'h00);
    chk("first_outstanding", outstanding_o, 1);

    // Both requesters held continuously with immediate acks, until the in-flight limit.
    do_reset();
    set_cfg($urandom, 12'($urandom));
    set_usr($urandom, 12'($urandom));
    prev = 0;
    for (int unsigned i = 0; i < MAXO; i++) begin
      do_issue(0, 1'b0, 1'b0);
      if (i != 0) chk("issue_spacing", last_issue_cyc - prev, 3);
      prev = last_issue_cyc;
    end
    repeat (3) begin
      tick();
      chk("full_no_grant", rd_req_o, 1'b0);
    end
    do_cpl(8'h81, 1'b1, {$urandom, $urandom});
    chk("freed_outstanding", outstanding_o, MAXO - 1);
    do_issue(0, 1'b0, 1'b0);

    // Ack and last completion in the same cycle at two in flight.
    do_reset();
    set_cfg($urandom, 12'($urandom));
    do_issue(1, 1'b1, 1'b0);
    set_usr($urandom, 12'($urandom));
    do_issue(0, 1'b1, 1'b0);
    set_cfg($urandom, 12'($urandom));
    do_issue(0, 1'b1, 1'b1);
    chk("ack_and_cpl", outstanding_o, 2);

    // Last beat with nothing in flight: routed, no underflow, sticky error.
    do_reset();
    do_cpl(8'h81, 1'b1, 64'hDEAD_BEEF_0123_4567);
    repeat (3) tick();
    chk("err_sticky", err_o, 1'b1);
    chk("no_underflow", outstanding_o, 0);

    // Stray ack outside ISSUE.
    do_reset();
    rd_req_ack_i = 1'b1;
    #1;
    chk("stray_no_ack", {cfg_rd_req_ack_o, usr_rd_req_ack_o}, 0);
    tick();
    rd_req_ack_i = 1'b0;
    chk("stray_err", err_o, 1'b1);
    chk("stray_no_count", outstanding_o, 0);

    // Reset while a request is in ISSUE, then a stale completion.
    do_reset();
    set_cfg($urandom, 12'($urandom));
    do_issue(0, 1'b1, 1'b0);
    set_cfg($urandom, 12'($urandom));
    tick();
    chk("pre_rst_issue", rd_req_o, 1'b1);
    i_rst = 1'b1;
    cfg_rd_req_i = 1'b0;
    #1;
    chk("rst_issue_no_ack", {cfg_rd_req_ack_o, usr_rd_req_ack_o}, 0);
    tick();
    chk("rst_issue_drop", rd_req_o, 1'b0);
    chk("rst_issue_out", outstanding_o, 0);
    tick();
    i_rst = 1'b0;
    m_out = 0; m_err = 1'b0; m_last_usr = 1'b1; m_seq = '0;
    inflight.delete();
    do_cpl(8'h00, 1'b1, {$urandom, $urandom});
    do_reset();
    set_cfg($urandom, 12'($urandom));
    do_issue(1, 1'b1, 1'b0);
    chk("post_rst_tag", last_tag_seen, 8'h00);

    // Randomized traffic long enough for the sequence number to wrap.
    do_reset();
    for (int unsigned i = 0; i < 129; i++) begin
      if (!cfg_rd_req_i && !usr_rd_req_i && inflight.size() != 0) begin
        if ($urandom_range(0, 2) == 0) do_cpl(inflight[0], 1'b0, {$urandom, $urandom});
        if ($urandom_range(0, 1) == 0) do_cpl(inflight.pop_front(), 1'b1, {$urandom, $urandom});
      end
      if (!cfg_rd_req_i && $urandom_range(0, 1) == 1) set_cfg($urandom, 12'($urandom));
      if (!usr_rd_req_i && $urandom_range(0, 1) == 1) set_usr($urandom, 12'($urandom));
      if (!cfg_rd_req_i && !usr_rd_req_i) set_cfg($urandom, 12'($urandom));
      wc = (m_out >= 2) || ((m_out == 1) && ($urandom_range(0, 1) == 1));
      do_issue($urandom_range(0, 2), 1'b1, wc);
      if (i == 128) chk("seq_wrap", {1'b0, last_tag_seen[6:0]}, 8'h00);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rd_req_arbiter.md
RD_REQ_ARBITER -- requirements
Module: rd_req_arbiter

Interface
REQ-001 SHALL have parameter: MAX_OUTSTANDING, 4, maximum acked-but-uncompleted read requests in flight (legal 1..15).
REQ-002 SHALL have ports, one clock; reset is synchronous and active-high:
- i_pcie_clk  in  1  sole clock
- i_rst  in  1  synchronous, active-high reset
- cfg_rd_req_i / cfg_rd_req_addr_i / cfg_rd_req_len_i  in  1/32/12  config-stream read request, held until acked
- cfg_rd_req_ack_o  out  1  config request accepted
- usr_rd_req_i / usr_rd_req_addr_i / usr_rd_req_len_i  in  1/32/12  user DMA read request, held until acked
- usr_rd_req_ack_o  out  1  user request accepted
- rd_req_o / rd_req_addr_o / rd_req_len_o / rd_req_tag_o  out  1/32/12/8  shared request to PCIe engine
- rd_req_ack_i  in  1  PCIe engine accepted rd_req_o
- cpl_valid_i / cpl_tag_i / cpl_data_i / cpl_last_i  in  1/8/64/1  completion beat; last flags final beat of a request
- cfg_data_o / cfg_data_valid_o  out  64/1  completion data to config path
- usr_data_o / usr_data_valid_o  out  64/1  completion data to user path
- outstanding_o  out  4  requests in flight
- err_o  out  1  sticky protocol error

Function
REQ-003 SHALL implement FSM IDLE -> ISSUE -> GAP -> IDLE.
REQ-004 IDLE: if a request is pending and outstanding_o < MAX_OUTSTANDING, SHALL grant one requester, register its addr/len onto rd_req_addr_o/rd_req_len_o, assert rd_req_o next cycle, enter ISSUE.
REQ-005 Arbitration SHALL be round-robin: when both pending, grant the one not granted last; single pending wins immediately.
REQ-006 ISSUE: rd_req_o, addr, len, tag SHALL stay stable until rd_req_ack_i; on ack, rd_req_o deasserts next cycle and FSM enters GAP.
REQ-007 Granted requester's *_ack_o SHALL equal rd_req_ack_i & (in ISSUE) & grant (combinational, one-cycle pulse); the other ack stays 0.
REQ-008 GAP SHALL last exactly one cycle and ignore all requests, absorbing the requester's one-cycle deassertion lag.
REQ-009 rd_req_tag_o SHALL be {owner, seq[6:0]}: owner 0 = cfg, 1 = usr; seq is a shared 7-bit counter incremented on each accepted request, wrapping 127 -> 0.
REQ-010 outstanding_o SHALL +1 on rd_req_ack_i, -1 on cpl_valid_i & cpl_last_i, unchanged when both occur in one cycle.
REQ-011 Completion routing SHALL have 1-cycle latency: cpl_tag_i[7]=0 -> cfg_data_o/cfg_data_valid_o, 1 -> usr_data_o/usr_data_valid_o; the non-selected valid is 0.
REQ-012 Data outputs SHALL register cpl_data_i every cycle; only valids are gated.
REQ-013 A last beat with outstanding_o == 0 SHALL still be routed, SHALL NOT decrement (no underflow), and SHALL set err_o.
REQ-014 rd_req_ack_i outside ISSUE SHALL be ignored for counting and SHALL set err_o.
REQ-015 At outstanding_o == MAX_OUTSTANDING, no grant; a simultaneous last completion frees the slot for grant next cycle.

Reset
REQ-016 On i_rst, at the next edge: FSM = IDLE; rd_req_o, both valids, both acks, err_o, outstanding_o, seq = 0; last-grant = usr so cfg wins first contention.
REQ-017 Reset mid-ISSUE SHALL drop the request without ack; in-flight completions after reset SHALL still route by tag, each last beat setting err_o per REQ-013.

Configuration
REQ-018 With RD_ARB_CFG_PRIORITY_EN defined, arbitration SHALL be strict priority to cfg (usr granted only when cfg_rd_req_i is low in IDLE); undefined, round-robin per REQ-005.

Verification
REQ-019 Only cfg_rd_req_i=1, addr 0x1000, len 0 -> rd_req_o next cycle, addr 0x1000, len 0, tag 0x00; ack 2 cycles later -> cfg_rd_req_ack_o one pulse, outstanding_o=1.
REQ-020 Both requests held continuously, immediate acks -> grants cfg,usr,cfg,usr; tags 0x00,0x81,0x02,0x83; each issue 3 cycles apart (macro defined: all cfg).
REQ-021 MAX_OUTSTANDING=4, 4 acked, no completions -> no rd_req_o; one last beat, tag 0x81 -> usr_data_valid_o 1 cycle later, outstanding 3, new request issued.
REQ-022 Ack and last beat in same cycle at outstanding 2 -> stays 2; 128 accepted requests -> seq wraps, tag 0x00 reappears.
REQ-023 Last beat at outstanding 0 -> data routed, outstanding stays 0, err_o=1 until i_rst.
REQ-024 i_rst in ISSUE -> rd_req_o=0 next cycle, no ack pulse, outstanding 0; later cfg request gets tag 0x00.
